// File: rtl/mesi_isc_cache_agent.sv
// MESI cache-side agent: CPU requests to mbus commands, cbus snoop/enable responses.
// Holds a direct-mapped MESI state and tag table; carries no data.
module mesi_isc_cache_agent #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int IDX_WIDTH      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_i,
  input  logic                      cpu_wr_i,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr_i,
  output logic                      cpu_busy_o,
  output logic                      cpu_done_o,
  output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
  output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
  input  logic                      mbus_ack_i,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  output logic                      cbus_ack_o
);

  localparam int LINES = 2 ** IDX_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - IDX_WIDTH;

  localparam logic [MBUS_CMD_WIDTH-1:0] M_NOP = 0;
  localparam logic [MBUS_CMD_WIDTH-1:0] M_WR  = 1;
  localparam logic [MBUS_CMD_WIDTH-1:0] M_RD  = 2;
  localparam logic [MBUS_CMD_WIDTH-1:0] M_WRB = 3;
  localparam logic [MBUS_CMD_WIDTH-1:0] M_RDB = 4;

  localparam logic [CBUS_CMD_WIDTH-1:0] C_NOP  = 0;
  localparam logic [CBUS_CMD_WIDTH-1:0] C_WRS  = 1;
  localparam logic [CBUS_CMD_WIDTH-1:0] C_RDS  = 2;
  localparam logic [CBUS_CMD_WIDTH-1:0] C_ENWR = 3;
  localparam logic [CBUS_CMD_WIDTH-1:0] C_ENRD = 4;

  typedef enum logic [1:0] {
    ST_I, ST_S, ST_E, ST_M
  } mesi_t;

  typedef enum logic [2:0] {
    IDLE, EVICT, BROAD, WAIT_EN,
    MEM, DONE, SNP_WB, SNP_ACK
  } fsm_t;

  fsm_t                  state;
  fsm_t                  ret_state;
  mesi_t                 line_st  [LINES];
  logic [TAG_W-1:0]      line_tag [LINES];
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] snp_addr;
  logic                  snp_rd;

  logic [IDX_WIDTH-1:0]  cpu_idx;
  logic [TAG_W-1:0]      cpu_tag;
  mesi_t                 cpu_st;
  logic                  cpu_hit;
  logic [IDX_WIDTH-1:0]  cb_idx;
  mesi_t                 cb_st;
  logic                  cb_hit;
  logic                  cb_valid;
  logic                  cb_snoop;
  logic                  cb_en;
  logic [IDX_WIDTH-1:0]  req_idx;
  logic [IDX_WIDTH-1:0]  snp_idx;

  assign cpu_idx = cpu_addr_i[IDX_WIDTH-1:0];
  assign cpu_tag = cpu_addr_i[ADDR_WIDTH-1:IDX_WIDTH];
  assign cpu_st  = line_st[cpu_idx];
  assign cpu_hit = (line_tag[cpu_idx] == cpu_tag)
                && (cpu_st != ST_I);

  assign cb_idx = cbus_addr_i[IDX_WIDTH-1:0];
  assign cb_st  = line_st[cb_idx];
  assign cb_hit = (line_tag[cb_idx]
                   == cbus_addr_i[ADDR_WIDTH-1:IDX_WIDTH])
               && (cb_st != ST_I);

  // A command still present while our ack is high is the same command.
  assign cb_valid = (cbus_cmd_i != C_NOP) && !cbus_ack_o;
  assign cb_snoop = cb_valid
                 && (cbus_cmd_i == C_WRS || cbus_cmd_i == C_RDS);
  assign cb_en    = cb_valid
                 && (cbus_cmd_i == C_ENWR || cbus_cmd_i == C_ENRD);

  assign req_idx = req_addr[IDX_WIDTH-1:0];
  assign snp_idx = snp_addr[IDX_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ret_state   <= IDLE;
      req_addr    <= '0;
      req_wr      <= 1'b0;
      snp_addr    <= '0;
      snp_rd      <= 1'b0;
      cpu_busy_o  <= 1'b0;
      cpu_done_o  <= 1'b0;
      mbus_cmd_o  <= M_NOP;
      mbus_addr_o <= '0;
      cbus_ack_o  <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        line_st[i]  <= ST_I;
        line_tag[i] <= '0;
      end
    end else begin
      cbus_ack_o <= 1'b0;
      cpu_done_o <= 1'b0;
      if ((state == IDLE || state == WAIT_EN) && cb_snoop) begin
        if (cb_hit && cb_st == ST_M) begin
          ret_state <= state;
          snp_addr  <= cbus_addr_i;
          snp_rd    <= (cbus_cmd_i == C_RDS);
          state     <= SNP_WB;
        end else begin
          cbus_ack_o <= 1'b1;
          if (cb_hit)
            line_st[cb_idx] <= (cbus_cmd_i == C_RDS) ? ST_S : ST_I;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (cpu_req_i) begin
              req_addr   <= cpu_addr_i;
              req_wr     <= cpu_wr_i;
              cpu_busy_o <= 1'b1;
              priority case (1'b1)
                cpu_hit && (!cpu_wr_i || cpu_st != ST_S): begin
                  if (cpu_wr_i)
                    line_st[cpu_idx] <= ST_M;
                  state <= DONE;
                end
                cpu_hit:          state <= BROAD;
                cpu_st == ST_M:   state <= EVICT;
                default:          state <= BROAD;
              endcase
            end
          end
          EVICT: begin
            if (mbus_cmd_o == M_NOP) begin
              mbus_cmd_o  <= M_WR;
              mbus_addr_o <= {line_tag[req_idx], req_idx};
            end else if (mbus_ack_i) begin
              mbus_cmd_o       <= M_NOP;
              line_st[req_idx] <= ST_I;
              state            <= BROAD;
            end
          end
          BROAD: begin
            if (mbus_cmd_o == M_NOP) begin
              mbus_cmd_o  <= req_wr ? M_WRB : M_RDB;
              mbus_addr_o <= req_addr;
            end else if (mbus_ack_i) begin
              mbus_cmd_o <= M_NOP;
              state      <= WAIT_EN;
            end
          end
          WAIT_EN: begin
            if (cb_en) begin
              cbus_ack_o <= 1'b1;
              if (cbus_addr_i == req_addr)
                state <= MEM;
            end
          end
          MEM: begin
            if (mbus_cmd_o == M_NOP) begin
              mbus_cmd_o  <= req_wr ? M_WR : M_RD;
              mbus_addr_o <= req_addr;
            end else if (mbus_ack_i) begin
              mbus_cmd_o        <= M_NOP;
              line_st[req_idx]  <= req_wr ? ST_M : ST_S;
              line_tag[req_idx] <= req_addr[ADDR_WIDTH-1:IDX_WIDTH];
              state             <= DONE;
            end
          end
          DONE: begin
            cpu_done_o <= 1'b1;
            cpu_busy_o <= 1'b0;
            state      <= IDLE;
          end
          SNP_WB: begin
            if (mbus_cmd_o == M_NOP) begin
              mbus_cmd_o  <= M_WR;
              mbus_addr_o <= snp_addr;
            end else if (mbus_ack_i) begin
              mbus_cmd_o       <= M_NOP;
              line_st[snp_idx] <= snp_rd ? ST_S : ST_I;
              state            <= SNP_ACK;
            end
          end
          SNP_ACK: begin
            cbus_ack_o <= 1'b1;
            state      <= ret_state;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mesi_isc_cache_agent.sv
// Directed bench for mesi_isc_cache_agent: mbus auto-responder,
// cbus command driver, line table observed hierarchically.
module tb_mesi_isc_cache_agent;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic        cpu_busy;
  logic        cpu_done;
  logic [2:0]  mbus_cmd;
  logic [31:0] mbus_addr;
  logic        mbus_ack;
  logic [2:0]  cbus_cmd;
  logic [31:0] cbus_addr;
  logic        cbus_ack;

  int checks = 0;
  int fails  = 0;
  int ack_cnt = 0;
  int dbl = 0;
  bit prev_ack = 1'b0;
  bit auto_ack = 1'b1;
  logic [2:0]  cmd_q [$];
  logic [31:0] addr_q [$];

  mesi_isc_cache_agent dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req_i   (cpu_req),
    .cpu_wr_i    (cpu_wr),
    .cpu_addr_i  (cpu_addr),
    .cpu_busy_o  (cpu_busy),
    .cpu_done_o  (cpu_done),
    .mbus_cmd_o  (mbus_cmd),
    .mbus_addr_o (mbus_addr),
    .mbus_ack_i  (mbus_ack),
    .cbus_cmd_i  (cbus_cmd),
    .cbus_addr_i (cbus_addr),
    .cbus_ack_o  (cbus_ack)
  );

  always #5 clk = ~clk;

  // mbus acks any pending command at once and logs it
  always @(negedge clk) begin
    if (auto_ack && mbus_cmd != 3'd0 && !rst) begin
      mbus_ack = 1'b1;
      cmd_q.push_back(mbus_cmd);
      addr_q.push_back(mbus_addr);
    end else begin
      mbus_ack = 1'b0;
    end
    if (cbus_ack) ack_cnt++;
    if (cbus_ack && prev_ack) dbl++;
    prev_ack = cbus_ack;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ent(input int i);
    return {29'd0, cmd_q[i], addr_q[i]};
  endfunction

  task automatic issue(input logic wr, input logic [31:0] a);
    cpu_req  = 1'b1;
    cpu_wr   = wr;
    cpu_addr = a;
    @(negedge clk);
    cpu_req  = 1'b0;
  endtask

  task automatic cbus_send(input logic [2:0] c,
                           input logic [31:0] a,
                           input int lim,
                           output bit ok);
    ok = 1'b0;
    cbus_cmd  = c;
    cbus_addr = a;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (cbus_ack) begin
        ok = 1'b1;
        break;
      end
    end
    cbus_cmd = 3'd0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      if (cpu_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_log(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_q.size() > n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int a0;
    int cyc;
    bit ok;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_wr    = 1'b0;
    cpu_addr  = '0;
    mbus_ack  = 1'b0;
    cbus_cmd  = 3'd0;
    cbus_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_mbus_cmd", 64'(mbus_cmd), 64'd0);
    chk("rst_cbus_ack", 64'(cbus_ack), 64'd0);
    chk("rst_busy", 64'(cpu_busy), 64'd0);
    chk("rst_done", 64'(cpu_done), 64'd0);
    chk("rst_line0", 64'(dut.line_st[0]), 64'd0);

    // read miss 0x10
    n = cmd_q.size();
    a0 = ack_cnt;
    issue(1'b0, 32'h10);
    cbus_send(3'd4, 32'h10, 100, ok);
    chk("rdmiss_en_ack", 64'(ok), 64'd1);
    wait_done(cyc, ok);
    chk("rdmiss_done", 64'(ok), 64'd1);
    chk("rdmiss_ncmd", 64'(cmd_q.size() - n), 64'd2);
    chk("rdmiss_cmd0", ent(n), 64'h4_0000_0010);
    chk("rdmiss_cmd1", ent(n + 1), 64'h2_0000_0010);
    chk("rdmiss_st", 64'(dut.line_st[0]), 64'd1);
    chk("rdmiss_tag", 64'(dut.line_tag[0]), 64'd2);
    chk("rdmiss_acks", 64'(ack_cnt - a0), 64'd1);

    // write hit on S
    n = cmd_q.size();
    issue(1'b1, 32'h10);
    cbus_send(3'd3, 32'h10, 100, ok);
    chk("wrs_en_ack", 64'(ok), 64'd1);
    wait_done(cyc, ok);
    chk("wrs_done", 64'(ok), 64'd1);
    chk("wrs_cmd0", ent(n), 64'h3_0000_0010);
    chk("wrs_cmd1", ent(n + 1), 64'h1_0000_0010);
    chk("wrs_st", 64'(dut.line_st[0]), 64'd3);

    // write hit on M
    n = cmd_q.size();
    issue(1'b1, 32'h10);
    wait_done(cyc, ok);
    chk("wrm_done", 64'(ok), 64'd1);
    chk("wrm_latency", 64'(cyc + 1), 64'd2);
    chk("wrm_nocmd", 64'(cmd_q.size() - n), 64'd0);
    chk("wrm_busy", 64'(cpu_busy), 64'd0);

    // write snoop on M line
    n = cmd_q.size();
    a0 = ack_cnt;
    cbus_send(3'd1, 32'h10, 100, ok);
    @(negedge clk);
    chk("wsnp_ack", 64'(ok), 64'd1);
    chk("wsnp_ncmd", 64'(cmd_q.size() - n), 64'd1);
    chk("wsnp_wb", ent(n), 64'h1_0000_0010);
    chk("wsnp_st", 64'(dut.line_st[0]), 64'd0);
    chk("wsnp_acks", 64'(ack_cnt - a0), 64'd1);

    // refill line0 M, then read 0x20 evicts it
    issue(1'b1, 32'h10);
    cbus_send(3'd3, 32'h10, 100, ok);
    wait_done(cyc, ok);
    chk("refill_st", 64'(dut.line_st[0]), 64'd3);
    n = cmd_q.size();
    issue(1'b0, 32'h20);
    cbus_send(3'd4, 32'h20, 100, ok);
    wait_done(cyc, ok);
    chk("evict_done", 64'(ok), 64'd1);
    chk("evict_wb", ent(n), 64'h1_0000_0010);
    chk("evict_brd", ent(n + 1), 64'h4_0000_0020);
    chk("evict_rd", ent(n + 2), 64'h2_0000_0020);
    chk("evict_st", 64'(dut.line_st[0]), 64'd1);
    chk("evict_tag", 64'(dut.line_tag[0]), 64'd4);

    // snoops while waiting for enable
    issue(1'b0, 32'h18);
    cbus_send(3'd4, 32'h18, 100, ok);
    wait_done(cyc, ok);
    chk("rd18_tag", 64'(dut.line_tag[0]), 64'd3);
    n = cmd_q.size();
    a0 = ack_cnt;
    issue(1'b1, 32'h30);
    wait_log(n, ok);
    chk("w30_brd_seen", 64'(ok), 64'd1);
    chk("w30_brd", ent(n), 64'h3_0000_0030);
    cbus_send(3'd2, 32'h18, 100, ok);
    @(negedge clk);
    chk("wen_rsnp_ack", 64'(ok), 64'd1);
    chk("wen_rsnp_st", 64'(dut.line_st[0]), 64'd1);
    cbus_send(3'd1, 32'h18, 100, ok);
    @(negedge clk);
    chk("wen_wsnp_ack", 64'(ok), 64'd1);
    chk("wen_wsnp_st", 64'(dut.line_st[0]), 64'd0);
    cbus_send(3'd5, 32'h18, 8, ok);
    chk("wen_cmd5_noack", 64'(ok), 64'd0);
    cbus_send(3'd3, 32'h40, 100, ok);
    repeat (3) @(negedge clk);
    chk("wen_other_ack", 64'(ok), 64'd1);
    chk("wen_other_busy", 64'(cpu_busy), 64'd1);
    chk("wen_other_nomem", 64'(cmd_q.size() - n), 64'd1);
    cbus_send(3'd3, 32'h30, 100, ok);
    wait_done(cyc, ok);
    chk("w30_done", 64'(ok), 64'd1);
    chk("w30_mem", ent(n + 1), 64'h1_0000_0030);
    chk("w30_st", 64'(dut.line_st[0]), 64'd3);
    chk("w30_tag", 64'(dut.line_tag[0]), 64'd6);
    chk("w30_acks", 64'(ack_cnt - a0), 64'd4);

    // reset during unacked broadcast
    auto_ack = 1'b0;
    issue(1'b0, 32'h51);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("hold_brd", {29'd0, mbus_cmd, mbus_addr},
          64'h4_0000_0051);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_cmd", 64'(mbus_cmd), 64'd0);
    chk("mrst_busy", 64'(cpu_busy), 64'd0);
    chk("mrst_done", 64'(cpu_done), 64'd0);
    chk("mrst_cack", 64'(cbus_ack), 64'd0);
    chk("mrst_line0", 64'(dut.line_st[0]), 64'd0);
    chk("mrst_line1", 64'(dut.line_st[1]), 64'd0);
    rst = 1'b0;
    auto_ack = 1'b1;
    @(negedge clk);
    chk("no_double_ack", 64'(dbl), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
